mem_port_unit: RTL and testbench

Parametrised load/store port between the multicycle core and its single shared memory bus. It replaces the bare word-wide, zero-wait memory connection with a request/response handshake on both sides. It supports byte, half and word (and double when XLEN=64) accesses with sign/zero extension, byte enables, wait states and misalignment detection. It is instantiated once per core and serves both instruction fetch and data access.

---
 rtl/mem_port_unit_pkg.sv | 27 ++
 rtl/mem_port_unit_load_extend.sv | 30 +++
 rtl/mem_port_unit.sv | 129 ++++++++++++
 tb/tb_mem_port_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_unit_pkg.sv
// mem_port_unit_pkg: shared size encodings, FSM states and byte-enable helper
package mem_port_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        RESP
    } state_e;

    // Lane mask for an aligned access of the given size starting at byte offset
    function automatic logic [7:0] byte_enable(input size_e size, input logic [2:0] offset);
        logic [7:0] base;
        base = size == SIZE_B ? 8'h01 :
               size == SIZE_H ? 8'h03 :
               size == SIZE_W ? 8'h0F : 8'hFF;
        return base << offset;
    endfunction

endpackage

// File: rtl/mem_port_unit_load_extend.sv
// load_extend: right-align a bus word by byte offset, select the access size and sign/zero-extend
module load_extend
    import mem_port_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              data,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  size_e                        size,
    input  logic                         is_unsigned,
    output logic [XLEN-1:0]              result
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [6:0]      nbits;
    logic            sign;

    // The sign bit is picked with the top bit of the size mask to avoid a variable index
    always_comb begin
        shifted = data >> {offset, 3'b000};
        nbits   = size == SIZE_B ? 7'd8 :
                  size == SIZE_H ? 7'd16 :
                  (size == SIZE_W || XLEN == 32) ? 7'd32 : 7'd64;
        mask    = ~({XLEN{1'b1}} << nbits);
        sign    = ~is_unsigned & |(shifted & (mask ^ (mask >> 1)));
        result  = (shifted & mask) | ({XLEN{sign}} & ~mask);
    end

endmodule

// File: rtl/mem_port_unit.sv
// mem_port_unit: request/response load/store port onto a single shared memory bus
module mem_port_unit
    import mem_port_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_error,
    output logic                memory_valid,
    input  logic                memory_ready,
    output logic [ADDR_W-1:0]   memory_address,
    output logic                memory_write_enable,
    output logic [XLEN/8-1:0]   memory_byte_enable,
    output logic [XLEN-1:0]     memory_data_out,
    input  logic [XLEN-1:0]     memory_data_in,
    input  logic                memory_rvalid
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    state_e              state_q, state_d;
    size_e               size_q, size_d, req_sz;
    logic                write_q, write_d;
    logic                uns_q, uns_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [XLEN-1:0]     ext;
    logic [XLEN-1:0]     lane_data;
    logic [OW-1:0]       off;
    logic                mis;

    assign off = addr_q[OW-1:0];

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .data        (memory_data_in),
        .offset      (off),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext)
    );

    // Next state: latch the request in IDLE, wait for grant, then for read data
    always_comb begin
        req_sz  = size_e'(req_size);
        mis     = req_sz == SIZE_H ? req_addr[0] :
                  req_sz == SIZE_W ? |req_addr[1:0] :
                  req_sz == SIZE_D ? (XLEN == 32) || |req_addr[2:0] : 1'b0;
        state_d = state_q;
        size_d  = size_q;
        write_d = write_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d = req_write;
                size_d  = req_sz;
                uns_d   = req_unsigned;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                err_d   = mis;
                rdata_d = '0;
                state_d = mis ? RESP : REQ;
            end
            REQ:    if (memory_ready) state_d = write_q ? RESP : WAIT_R;
            WAIT_R: if (memory_rvalid) begin
                rdata_d = ext;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register and latched request only
    always_comb begin
        lane_data           = wdata_q << {off, 3'b000};
        memory_valid        = state_q == REQ;
        memory_address      = memory_valid ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
        memory_write_enable = memory_valid & write_q;
        memory_byte_enable  = memory_valid ? NB'(byte_enable(size_q, 3'(off))) : '0;
        memory_data_out     = '0;
        for (int i = 0; i < NB; i++)
            memory_data_out[8*i +: 8] = memory_byte_enable[i] ? lane_data[8*i +: 8] : 8'h00;
        req_ready           = state_q == IDLE;
        rsp_valid           = state_q == RESP;
        rsp_error           = rsp_valid & err_q;
        rsp_rdata           = rsp_valid ? rdata_q : '0;
    end

    // State and request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            size_q  <= SIZE_B;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_unit.sv
// tb_mem_port_unit: directed checks of a 32-bit and a 64-bit port driven by shared stimulus
module tb_mem_port_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        memory_ready = 1'b0;
    logic [63:0] memory_data_in = '0;
    logic        memory_rvalid = 1'b0;

    logic        a_req_ready, a_rsp_valid, a_rsp_error, a_memory_valid, a_memory_write_enable;
    logic [31:0] a_rsp_rdata, a_memory_address, a_memory_data_out;
    logic [3:0]  a_memory_byte_enable;
    logic        b_req_ready, b_rsp_valid, b_rsp_error, b_memory_valid, b_memory_write_enable;
    logic [63:0] b_rsp_rdata, b_memory_data_out;
    logic [31:0] b_memory_address;
    logic [7:0]  b_memory_byte_enable;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .req_valid           (req_valid),
        .req_ready           (a_req_ready),
        .req_write           (req_write),
        .req_size            (req_size),
        .req_unsigned        (req_unsigned),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata[31:0]),
        .rsp_valid           (a_rsp_valid),
        .rsp_rdata           (a_rsp_rdata),
        .rsp_error           (a_rsp_error),
        .memory_valid        (a_memory_valid),
        .memory_ready        (memory_ready),
        .memory_address      (a_memory_address),
        .memory_write_enable (a_memory_write_enable),
        .memory_byte_enable  (a_memory_byte_enable),
        .memory_data_out     (a_memory_data_out),
        .memory_data_in      (memory_data_in[31:0]),
        .memory_rvalid       (memory_rvalid)
    );

    mem_port_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk                 (clk),
        .resetn              (resetn),
        .req_valid           (req_valid),
        .req_ready           (b_req_ready),
        .req_write           (req_write),
        .req_size            (req_size),
        .req_unsigned        (req_unsigned),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .rsp_valid           (b_rsp_valid),
        .rsp_rdata           (b_rsp_rdata),
        .rsp_error           (b_rsp_error),
        .memory_valid        (b_memory_valid),
        .memory_ready        (memory_ready),
        .memory_address      (b_memory_address),
        .memory_write_enable (b_memory_write_enable),
        .memory_byte_enable  (b_memory_byte_enable),
        .memory_data_out     (b_memory_data_out),
        .memory_data_in      (memory_data_in),
        .memory_rvalid       (memory_rvalid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr, input logic [63:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    initial begin
        tick;
        tick;
        resetn = 1'b1;
        chk("reset req_ready", a_req_ready, 1);
        chk("reset rsp_valid", a_rsp_valid, 0);
        chk("reset mem_valid", a_memory_valid, 0);
        chk("reset mem_addr", a_memory_address, 0);
        chk("reset byte_en", a_memory_byte_enable, 0);
        chk("reset rdata", a_rsp_rdata, 0);
        chk("reset64 req_ready", b_req_ready, 1);

        memory_ready  = 1'b1;
        memory_rvalid = 1'b1;
        tick;
        memory_ready  = 1'b0;
        memory_rvalid = 1'b0;
        chk("spurious req_ready", a_req_ready, 1);
        chk("spurious rsp_valid", a_rsp_valid, 0);
        chk("spurious mem_valid", a_memory_valid, 0);
        tick;
        chk("spurious rsp_valid2", a_rsp_valid, 0);
        chk("spurious req_ready2", a_req_ready, 1);

        request(1'b0, 2'b00, 1'b0, 32'h1003, 64'h0);
        tick;
        req_valid = 1'b0;
        chk("lb mem_valid", a_memory_valid, 1);
        chk("lb mem_addr", a_memory_address, 32'h1000);
        chk("lb byte_en", a_memory_byte_enable, 4'h8);
        chk("lb write_en", a_memory_write_enable, 0);
        chk("lb req_ready", a_req_ready, 0);
        chk("lb64 byte_en", b_memory_byte_enable, 8'h08);
        memory_ready = 1'b1;
        tick;
        memory_ready = 1'b0;
        chk("lb wait mem_valid", a_memory_valid, 0);
        chk("lb wait rsp_valid", a_rsp_valid, 0);
        memory_rvalid  = 1'b1;
        memory_data_in = 64'h0000_0000_80FF_1234;
        tick;
        memory_rvalid = 1'b0;
        chk("lb rsp_valid", a_rsp_valid, 1);
        chk("lb rdata", a_rsp_rdata, 32'hFFFF_FF80);
        chk("lb error", a_rsp_error, 0);
        chk("lb64 rdata", b_rsp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        tick;
        chk("lb done rsp_valid", a_rsp_valid, 0);
        chk("lb done req_ready", a_req_ready, 1);

        request(1'b1, 2'b01, 1'b0, 32'h2002, 64'h0000_0000_0000_ABCD);
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sh mem_valid", a_memory_valid, 1);
            chk("sh byte_en", a_memory_byte_enable, 4'hC);
            chk("sh data_out", a_memory_data_out, 32'hABCD_0000);
            chk("sh write_en", a_memory_write_enable, 1);
            chk("sh rsp_valid early", a_rsp_valid, 0);
            if (i == 3) memory_ready = 1'b1;
            tick;
        end
        memory_ready = 1'b0;
        chk("sh64 rsp_valid", b_rsp_valid, 1);
        chk("sh rsp_valid", a_rsp_valid, 1);
        chk("sh rsp_error", a_rsp_error, 0);
        chk("sh rdata", a_rsp_rdata, 0);
        chk("sh mem_valid off", a_memory_valid, 0);
        tick;

        request(1'b0, 2'b10, 1'b0, 32'h0006, 64'h0);
        tick;
        req_valid = 1'b0;
        chk("mis rsp_valid", a_rsp_valid, 1);
        chk("mis rsp_error", a_rsp_error, 1);
        chk("mis rdata", a_rsp_rdata, 0);
        chk("mis mem_valid", a_memory_valid, 0);
        chk("mis64 rsp_error", b_rsp_error, 1);
        tick;
        chk("mis after mem_valid", a_memory_valid, 0);
        chk("mis after req_ready", a_req_ready, 1);

        request(1'b0, 2'b11, 1'b0, 32'h0000, 64'h0);
        tick;
        req_valid = 1'b0;
        chk("d32 rsp_error", a_rsp_error, 1);
        chk("d32 mem_valid", a_memory_valid, 0);
        chk("d64 mem_valid", b_memory_valid, 1);
        chk("d64 byte_en", b_memory_byte_enable, 8'hFF);
        memory_ready = 1'b1;
        tick;
        memory_ready   = 1'b0;
        chk("d32 idle mem_valid", a_memory_valid, 0);
        memory_rvalid  = 1'b1;
        memory_data_in = 64'h8001_0000_0000_0000;
        tick;
        memory_rvalid = 1'b0;
        chk("d64 rsp_valid", b_rsp_valid, 1);
        chk("d64 rdata", b_rsp_rdata, 64'h8001_0000_0000_0000);
        chk("d32 stray rvalid", a_rsp_valid, 0);
        tick;

        request(1'b0, 2'b01, 1'b1, 32'h0006, 64'h0);
        tick;
        req_valid = 1'b0;
        chk("lhu mem_addr", a_memory_address, 32'h4);
        chk("lhu byte_en", a_memory_byte_enable, 4'hC);
        chk("lhu64 mem_addr", b_memory_address, 32'h0);
        chk("lhu64 byte_en", b_memory_byte_enable, 8'hC0);
        memory_ready = 1'b1;
        tick;
        memory_ready  = 1'b0;
        memory_rvalid = 1'b1;
        tick;
        memory_rvalid = 1'b0;
        chk("lhu64 rdata", b_rsp_rdata, 64'h0000_0000_0000_8001);
        chk("lhu rdata", a_rsp_rdata, 0);
        tick;

        request(1'b0, 2'b10, 1'b0, 32'h0010, 64'h0);
        tick;
        req_valid    = 1'b0;
        memory_ready = 1'b1;
        tick;
        memory_ready = 1'b0;
        resetn       = 1'b0;
        tick;
        resetn = 1'b1;
        chk("rst req_ready", a_req_ready, 1);
        memory_rvalid  = 1'b1;
        memory_data_in = 64'hDEAD_BEEF_DEAD_BEEF;
        tick;
        memory_rvalid = 1'b0;
        chk("rst rsp_valid", a_rsp_valid, 0);
        chk("rst req_ready2", a_req_ready, 1);
        chk("rst mem_valid", a_memory_valid, 0);
        chk("rst mem_addr", a_memory_address, 0);
        chk("rst byte_en", a_memory_byte_enable, 0);
        chk("rst write_en", a_memory_write_enable, 0);
        chk("rst data_out", a_memory_data_out, 0);
        chk("rst64 rsp_valid", b_rsp_valid, 0);
        tick;
        chk("rst rsp_valid2", a_rsp_valid, 0);

        request(1'b1, 2'b00, 1'b0, 32'h1005, 64'h0000_0000_1234_5678);
        tick;
        chk("sb byte_en", a_memory_byte_enable, 4'h2);
        chk("sb data_out", a_memory_data_out, 32'h0000_7800);
        chk("sb64 byte_en", b_memory_byte_enable, 8'h20);
        chk("sb64 data_out", b_memory_data_out, 64'h0000_7800_0000_0000);
        memory_ready = 1'b1;
        request(1'b0, 2'b00, 1'b0, 32'h1001, 64'h0);
        tick;
        memory_ready = 1'b0;
        chk("sb rsp_valid", a_rsp_valid, 1);
        tick;
        chk("b2b idle req_ready", a_req_ready, 1);
        chk("b2b idle mem_valid", a_memory_valid, 0);
        tick;
        req_valid = 1'b0;
        chk("b2b mem_valid", a_memory_valid, 1);
        chk("b2b write_en", a_memory_write_enable, 0);
        memory_ready = 1'b1;
        tick;
        memory_ready   = 1'b0;
        memory_rvalid  = 1'b1;
        memory_data_in = 64'h0000_0000_0000_7F00;
        tick;
        memory_rvalid = 1'b0;
        chk("b2b rdata", a_rsp_rdata, 32'h0000_007F);
        chk("b2b64 rdata", b_rsp_rdata, 64'h0000_0000_0000_007F);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
